mem_arbiter: RTL

Shares one single-port unified memory between the pipelined CPU's instruction-fetch port and MEM-stage data port. Each pipeline step is sequenced as a data access first, then an instruction access. The arbiter freezes the whole pipeline with `stall` until both accesses have completed. It sits between the CPU core's `addrInst`/`instIn` and `addrData`/`dataIn`/`memWE`/`dataOut` ports and the external memory handshake.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_timeout.sv | 39 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: FSM state encoding, NOP word and watchdog defaults.
// Used by mem_arbiter and by arb_timeout, which is built only with ARB_TIMEOUT_EN.
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE = 2'd0,
        ARB_DATA = 2'd1,
        ARB_INST = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_e;

    localparam logic [31:0] ARB_NOP             = 32'h0000_0000;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
    localparam int unsigned ARB_CNT_WIDTH       = 16;

    function automatic logic arb_busy(input arb_state_e s);
        return (s == ARB_DATA) || (s == ARB_INST);
    endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Watchdog for one memory transaction: counts cycles without memAck and
// flags expiry in the cycle that would be the TIMEOUT-th unacknowledged one.
module arb_timeout
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic mem_ack,
    output logic expired
);

    localparam logic [ARB_CNT_WIDTH-1:0] LIMIT = ARB_CNT_WIDTH'(TIMEOUT - 1);

    logic [ARB_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !mem_ack) begin
            cnt_d = cnt_q + ARB_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && !mem_ack && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data access first, then instruction fetch, stalling
// the pipeline until both finish. Optional watchdog enabled by ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instReq,
    input  logic [31:0] addrInst,
    output logic [31:0] instOut,
    input  logic        dataReq,
    input  logic        dataWE,
    input  logic [31:0] addrData,
    input  logic [31:0] dataWr,
    output logic [31:0] dataRd,
    output logic        stall,
    output logic        memReq,
    output logic        memWE,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck,
    output logic        memErr
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be in 1..65535");
    end

    arb_state_e  state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inst_out_q, inst_out_d;
    logic [31:0] data_rd_q, data_rd_d;
    logic        inst_req_q, inst_req_d;
    logic        data_we_q, data_we_d;
    logic [31:0] addr_inst_q, addr_inst_d;
    logic        abort;
    logic        xfer_done;

    // memReq is high throughout DATA/INST, so memAck needs no extra qualification here.
    assign xfer_done = memAck || abort;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        inst_out_d  = inst_out_q;
        data_rd_d   = data_rd_q;
        inst_req_d  = inst_req_q;
        data_we_d   = data_we_q;
        addr_inst_d = addr_inst_q;
        case (state_q)
            ARB_IDLE: begin
                inst_req_d  = instReq;
                data_we_d   = dataWE;
                addr_inst_d = addrInst;
                if (dataReq) begin
                    state_d     = ARB_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dataWE;
                    mem_addr_d  = addrData;
                    mem_wdata_d = dataWr;
                end else if (instReq) begin
                    state_d    = ARB_INST;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addrInst;
                end
            end
            ARB_DATA: begin
                if (xfer_done) begin
                    if (!data_we_q) begin
                        data_rd_d = abort ? ARB_NOP : memRData;
                    end
                    if (inst_req_q) begin
                        state_d    = ARB_INST;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_inst_q;
                    end else begin
                        state_d   = ARB_DONE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            ARB_INST: begin
                if (xfer_done) begin
                    inst_out_d = abort ? ARB_NOP : memRData;
                    state_d    = ARB_DONE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                end
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inst_out_q  <= ARB_NOP;
            data_rd_q   <= '0;
            inst_req_q  <= 1'b0;
            data_we_q   <= 1'b0;
            addr_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            inst_out_q  <= inst_out_d;
            data_rd_q   <= data_rd_d;
            inst_req_q  <= inst_req_d;
            data_we_q   <= data_we_d;
            addr_inst_q <= addr_inst_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic tmo_clr;
    logic tmo_expired;
    logic mem_err_q, mem_err_d;

    assign tmo_clr = arb_busy(state_d) && (state_d != state_q);

    arb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (arb_busy(state_q)),
        .mem_ack(memAck),
        .expired(tmo_expired)
    );

    assign abort = tmo_expired;

    always_comb begin
        mem_err_d = mem_err_q || abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= mem_err_d;
        end
    end

    assign memErr = mem_err_q;
`else
    assign abort  = 1'b0;
    assign memErr = 1'b0;
`endif

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = arb_busy(state_q) || ((state_q == ARB_IDLE) && (instReq || dataReq));
        end
    end

    assign memReq   = mem_req_q;
    assign memWE    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWData = mem_wdata_q;
    assign instOut  = inst_out_q;
    assign dataRd   = data_rd_q;

endmodule
